// File: rtl/instruction_loader.sv
// instruction_loader
//   Writer side of the instruction-memory debug load port. Bytes arriving from
//   the UART RX are packed MSB-first into 32-bit words, and each word is written
//   to consecutive instruction-memory addresses starting at 0. A load ends after
//   HALT_WORD has been written, or after the last address has been filled
//   (flagged as overflow).
//
// Ports
//   clk              rising-edge system clock
//   rst              synchronous active-high reset
//   start            1-cycle pulse, arms a new load from IDLE or DONE
//   rx_data          received byte
//   rx_valid         1-cycle pulse, rx_data valid
//   wr_instruction   1-cycle write strobe to instruction memory
//   wr_addr          write address, zero-extended to 32 bits
//   data_instruction word to write
//   busy             load in progress (RECV or WRITE)
//   load_done        load finished, held until start or rst
//   overflow         memory filled without seeing HALT_WORD
//   words_loaded     words written in the current load
module instruction_loader #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_instruction,
  output logic [31:0]       wr_addr,
  output logic [31:0]       data_instruction,
  output logic              busy,
  output logic              load_done,
  output logic              overflow,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   WORD_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state_q,    state_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       shreg_q,    shreg_d;
  logic [ADDR_W:0]   words_q,    words_d;
  logic              overflow_q, overflow_d;
  logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
  logic [31:0]       data_q,     data_d;
  logic              wr_q;
  logic              busy_q;
  logic              done_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    words_d    = words_q;
    overflow_d = overflow_q;
    wr_addr_d  = wr_addr_q;
    data_d     = data_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // A byte arriving with start is dropped; counting begins with the next one.
        if (start) begin
          state_d    = S_RECV;
          addr_d     = '0;
          byte_cnt_d = '0;
          words_d    = '0;
          overflow_d = 1'b0;
        end
      end

      S_RECV: begin
        if (rx_valid) begin
          shreg_d    = {shreg_q[23:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Load the write outputs on the same edge that enters WRITE so the
          // strobe is visible one cycle after the 4th byte.
          if (byte_cnt_q == 2'd3) begin
            state_d   = S_WRITE;
            data_d    = {shreg_q[23:0], rx_data};
            wr_addr_d = addr_q;
            words_d   = words_q + WORD_ONE;
          end
        end
      end

      default: begin // S_WRITE
        byte_cnt_d = '0;
        if (shreg_q == HALT_WORD) begin
          state_d    = S_DONE;
          overflow_d = 1'b0;
        end else if (addr_q == LAST_ADDR) begin
          state_d    = S_DONE;
          overflow_d = 1'b1;
        end else begin
          state_d = S_RECV;
          addr_d  = addr_q + ADDR_ONE;
          // A byte landing in the write cycle starts the next word.
          if (rx_valid) begin
            shreg_d    = {shreg_q[23:0], rx_data};
            byte_cnt_d = 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      words_q    <= '0;
      overflow_q <= 1'b0;
      wr_addr_q  <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
      words_q    <= words_d;
      overflow_q <= overflow_d;
      wr_addr_q  <= wr_addr_d;
      data_q     <= data_d;
      // Status flags are registered from the next state so they line up with it.
      wr_q       <= (state_d == S_WRITE);
      busy_q     <= (state_d == S_RECV) || (state_d == S_WRITE);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign wr_instruction   = wr_q;
  assign wr_addr          = {{(32-ADDR_W){1'b0}}, wr_addr_q};
  assign data_instruction = data_q;
  assign busy             = busy_q;
  assign load_done        = done_q;
  assign overflow         = overflow_q;
  assign words_loaded     = words_q;

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_instruction;
  logic [31:0] wr_addr;
  logic [31:0] data_instruction;
  logic        busy;
  logic        load_done;
  logic        overflow;
  logic [5:0]  words_loaded;

  instruction_loader #(.DEPTH(32), .ADDR_W(5), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .wr_instruction   (wr_instruction),
    .wr_addr          (wr_addr),
    .data_instruction (data_instruction),
    .busy             (busy),
    .load_done        (load_done),
    .overflow         (overflow),
    .words_loaded     (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t expq[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest expected write, in the expected cycle.
  always @(negedge clk) begin
    if (wr_instruction) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h at cyc %0d, expected none",
                 wr_addr, data_instruction, cyc);
      end else begin
        wr_t e;
        e = expq.pop_front();
        if (e.cyc != cyc || e.addr != wr_addr || e.data != data_instruction) begin
          errors++;
          $display("FAIL write: got cyc=%0d addr=%h data=%h, expected cyc=%0d addr=%h data=%h",
                   cyc, wr_addr, data_instruction, e.cyc, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Write is expected in the cycle after the edge that samples the 4th byte.
  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
    wr_t e;
    e.cyc  = cyc + 1;
    e.addr = addr;
    e.data = data;
    expq.push_back(e);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input bit exp_wr,
                           input logic [31:0] addr);
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && exp_wr) expect_write(addr, w);
      send_byte(w[31-8*i -: 8]);
      repeat (gap) tick();
    end
  endtask

  task automatic chk_flags(input string tag, input logic b, input logic d,
                           input logic o, input logic [5:0] n);
    chk({tag, "_busy"},      {31'd0, busy},      {31'd0, b});
    chk({tag, "_load_done"}, {31'd0, load_done}, {31'd0, d});
    chk({tag, "_overflow"},  {31'd0, overflow},  {31'd0, o});
    chk({tag, "_words"},     {26'd0, words_loaded}, {26'd0, n});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

    // 1. Reset state; bytes while idle cause no write.
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_wr", {31'd0, wr_instruction}, 32'd0);
    chk("rst_addr", wr_addr, 32'd0);
    chk("rst_data", data_instruction, 32'd0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0, 6'd0);
    for (int i = 0; i < 5; i++) send_byte(8'h5A);
    tick();

    // 2/3. Two words then HALT.
    pulse_start();
    chk_flags("armed", 1'b1, 1'b0, 1'b0, 6'd0);
    send_word(32'h2001_0005, 1, 1'b1, 32'd0);
    send_word(32'h8C22_0004, 0, 1'b1, 32'd1);
    send_word(32'hFFFF_FFFF, 0, 1'b1, 32'd2);
    tick();
    chk_flags("halt", 1'b0, 1'b1, 1'b0, 6'd3);
    send_word(32'h1111_2222, 0, 1'b0, 32'd0);
    chk_flags("halt_after", 1'b0, 1'b1, 1'b0, 6'd3);

    // 4. Fill all 32 addresses; extra bytes (first one in the final write cycle) dropped.
    pulse_start();
    for (int i = 0; i < 32; i++)
      send_word(32'h1234_0000 | i, (i < 31) ? (i % 2) : 0, 1'b1, i);
    send_word(32'hAABB_CCDD, 0, 1'b0, 32'd0);
    tick();
    chk_flags("full", 1'b0, 1'b1, 1'b1, 6'd32);
    chk("full_addr", wr_addr, 32'd31);
    chk("full_data", data_instruction, 32'h1234_001F);

    // 5. Reset mid-word discards the partial word.
    pulse_start();
    chk_flags("restart", 1'b1, 1'b0, 1'b0, 6'd0);
    send_word(32'hCAFE_0001, 1, 1'b1, 32'd0);
    send_byte(8'hDE);
    send_byte(8'hAD);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_flags("midrst", 1'b0, 1'b0, 1'b0, 6'd0);
    repeat (3) tick();
    pulse_start();
    send_word(32'h0102_0304, 1, 1'b1, 32'd0);
    chk_flags("after_rst", 1'b1, 1'b0, 1'b0, 6'd1);

    // 6. start mid-word ignored; word completes at the next address.
    send_byte(8'h0A);
    send_byte(8'h0B);
    pulse_start();
    send_byte(8'h0C);
    expect_write(32'd1, 32'h0A0B_0C0D);
    send_byte(8'h0D);
    tick();
    chk_flags("mid_start", 1'b1, 1'b0, 1'b0, 6'd2);
    send_word(32'hFFFF_FFFF, 0, 1'b1, 32'd2);
    tick();
    chk_flags("done2", 1'b0, 1'b1, 1'b0, 6'd3);

    // start in DONE with a simultaneous byte: byte dropped, load restarts at 0.
    rx_data = 8'hEE; rx_valid = 1'b1; start = 1'b1;
    tick();
    rx_valid = 1'b0; start = 1'b0;
    chk_flags("rearm", 1'b1, 1'b0, 1'b0, 6'd0);
    send_word(32'h7766_5544, 0, 1'b1, 32'd0);
    tick();
    chk_flags("rearm_w", 1'b1, 1'b0, 1'b0, 6'd1);

    repeat (4) tick();
    chk("pending_writes", expq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
